async_fifo_flags: RTL and testbench
===================================

// Module: async_fifo_flags
// PURPOSE
//  Parametrised dual-clock FIFO that carries data words from the wr_clk domain to the rd_clk domain.
//  Pointers cross domains as Gray codes through SYNC_STAGES-deep flop synchronisers.
//  Adds to the basic full/empty FIFO: programmable almost-full and almost-empty flags,
//  per-domain fill counts, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) read mode.
//  Sits between producer/consumer blocks running on unrelated clocks.
// PARAMETERS
//  DATA_WIDTH    8  width of one data word
//  ADDR_WIDTH    4  log2(depth); DEPTH = 1<<ADDR_WIDTH; legal range 2..10
//  SYNC_STAGES   2  synchroniser depth per crossing; legal values 2 or 3
//  AFULL_THRESH  DEPTH-2  almost_full asserts when wr_count >= AFULL_THRESH
//  AEMPTY_THRESH 2  almost_empty asserts when rd_count <= AEMPTY_THRESH
//  FWFT          0  0 = standard read (data 1 cycle after rd_en), 1 = first-word-fall-through
// PORTS
//  wr_clk        in   1             write clock
//  wr_reset      in   1             write-domain reset
//  rd_clk        in   1             read clock
//  rd_reset      in   1             read-domain reset, asynchronous, active-high
//  wr_en         in   1             write request
//  wr_data       in   DATA_WIDTH    write word
//  full          out  1             no free entry (wr_clk)
//  almost_full   out  1             wr_count >= AFULL_THRESH (wr_clk)
//  wr_count      out  ADDR_WIDTH+1  write-side fill estimate (wr_clk)
//  overflow      out  1             1-cycle pulse: wr_en while full (wr_clk)
//  rd_en         in   1             read request / pop
//  rd_data       out  DATA_WIDTH    read word
//  empty         out  1             no valid entry (rd_clk)
//  almost_empty  out  1             rd_count <= AEMPTY_THRESH (rd_clk)
//  rd_count      out  ADDR_WIDTH+1  read-side fill estimate (rd_clk)
//  underflow     out  1             1-cycle pulse: rd_en while empty (rd_clk)
//  Reset wr_reset, asynchronous, active-high; clock wr_clk.
// BEHAVIOUR
//  Reset values:
//   - wr_reset clears full, almost_full, wr_count, overflow, the write pointers and the rd->wr synchroniser.
//   - rd_reset clears rd_data, underflow, rd_count, the read pointers and the wr->rd synchroniser.
//   - rd_reset sets empty=1 and almost_empty=1.
//   - Both resets are asserted overlapping to flush. A single-domain reset mid-operation is unsupported; contents are undefined after one.
//  Write side:
//   - wr_en && !full stores wr_data at wptr[ADDR_WIDTH-1:0] and advances wptr (binary+Gray, ADDR_WIDTH+1 bits).
//   - wr_en && full drops the word; wptr is unchanged and overflow pulses the next cycle.
//  Read side, FWFT=0:
//   - rd_en && !empty registers mem[rptr] onto rd_data next cycle and advances rptr.
//   - rd_data holds its value otherwise.
//  Read side, FWFT=1:
//   - rd_data presents the head word whenever empty=0; rd_en pops.
//   - empty reflects the output register, adding 1 rd_clk of latency.
//  Read side, both modes: rd_en && empty leaves state unchanged; underflow pulses next cycle.
//  Flag timing:
//   - full, empty, the almost flags and the counts are registered.
//   - They are computed from the next-state local pointer vs the synchronised remote pointer, so the flag updates in the same edge as the op that causes it.
//  Flag equations:
//   - full: wgray_next == {~rsync[MSB:MSB-1], rsync[MSB-2:0]}.
//   - empty: rgray_next == wsync.
//   - Counts: wptr - gray2bin(rsync) and gray2bin(wsync) - rptr, in modulo 2^(ADDR_WIDTH+1) arithmetic; always 0..DEPTH.
//  Pessimism:
//   - Crossing latency is SYNC_STAGES+1 cycles of the destination clock.
//   - full/almost_full deassert late and empty/almost_empty deassert late. They are never early, so no overflow or underflow of storage can occur.
//  Corner cases:
//   - Pointer wrap-around past 2*DEPTH needs no special-casing; the extra MSB disambiguates full from empty.
//   - Simultaneous read and write at DEPTH-1 or 1 entries are both accepted.
//   - Memory is written on wr_clk only. It has no reset.
// STRUCTURE
//  Shared package fifo_pkg:
//   - bin2gray/gray2bin functions
//   - fifo_mode_e {FIFO_STD, FIFO_FWFT}
//   - localparam MIN_SYNC_STAGES=2
//  Sub-module gray_sync: SYNC_STAGES-deep flop chain of width ADDR_WIDTH+1, async-reset to 0. It is instantiated once per crossing direction.
//  Elaboration-time $error if AFULL_THRESH > DEPTH, AEMPTY_THRESH >= DEPTH or SYNC_STAGES is outside 2..3.
// TESTING
//  DEPTH=8, FWFT=0, wr 100 MHz / rd 37 MHz:
//   - 8 writes -> full=1 after the 8th write edge, almost_full=1 at wr_count=6.
//   - A 9th write is dropped, with a 1-cycle overflow pulse.
//  Drain 8 words:
//   - Data is returned in order 0..7.
//   - empty=1 on the edge of the 8th pop.
//   - rd_en again -> underflow pulse, rd_data holds 7.
//  Wrap-around: 40 interleaved writes/reads, count 0..39 -> in-order check and no flag glitch across pointer wrap at 16.
//  FWFT=1:
//   - A single write of 0xA5 gives empty=0 and rd_data=0xA5 without rd_en, within SYNC_STAGES+2 rd_clk.
//   - rd_en -> empty=1.
//  Random 5k ops at 100/37 and 37/100 MHz -> scoreboard match, rd_count/wr_count always <= 8, full & empty never both 1.
//  Overlapping wr_reset/rd_reset asserted mid-stream with 5 words stored -> empty=1, full=0, counts=0, next write/read pair returns the new word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion, read-mode
// encoding and synchroniser depth floor.
package fifo_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned PTR_MAX_W       = 11;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int unsigned s = 1; s < PTR_MAX_W; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_flags_if.sv
// Producer/consumer handshake bundle of the dual-clock FIFO; the write group
// belongs to wr_clk, the read group to rd_clk.
interface async_fifo_flags_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_count;
  logic                  overflow;

  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, wr_count, overflow,
    input  rd_data, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, wr_count, overflow,
    output rd_data, empty, almost_empty, rd_count, underflow
  );
endinterface

// File: rtl/async_fifo_flags_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer entering another clock domain.
module gray_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_flags.sv
// Dual-clock FIFO with registered full/empty, almost flags, fill counts,
// overflow/underflow pulses and optional first-word-fall-through read.
module async_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned FWFT          = 0
) (
  input  logic               wr_clk,
  input  logic               wr_reset,
  input  logic               rd_clk,
  input  logic               rd_reset,
  async_fifo_flags_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam fifo_mode_e  MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 10) begin : g_bad_addr
    $error("ADDR_WIDTH must be within 2..10");
  end
  if (AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("AFULL_THRESH must not exceed DEPTH");
  end
  if (AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
    $error("AEMPTY_THRESH must be below DEPTH");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2 or 3");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wbin, wgray, wbin_next, wgray_next, rsync, rsync_bin, wfill_next;
  logic [ADDR_WIDTH:0] rbin, rgray, rbin_next, rgray_next, wsync, wsync_bin, rfill_next;
  logic                wr_ok, fetch, ptr_empty, out_valid, out_valid_next;

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk(wr_clk), .rst(wr_reset), .d(rgray), .q(rsync)
  );

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk(rd_clk), .rst(rd_reset), .d(wgray), .q(wsync)
  );

  always_comb begin
    wr_ok      = bus.wr_en && !bus.full;
    wbin_next  = wbin + PW'(wr_ok);
    wgray_next = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
    rsync_bin  = PW'(gray2bin(PTR_MAX_W'(rsync)));
    wfill_next = wbin_next - rsync_bin;
  end

  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      wbin            <= '0;
      wgray           <= '0;
      bus.full        <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.wr_count    <= '0;
      bus.overflow    <= 1'b0;
    end else begin
      wbin            <= wbin_next;
      wgray           <= wgray_next;
      bus.full        <= (wgray_next == {~rsync[ADDR_WIDTH:ADDR_WIDTH-1], rsync[ADDR_WIDTH-2:0]});
      bus.almost_full <= (wfill_next >= PW'(AFULL_THRESH));
      bus.wr_count    <= wfill_next;
      bus.overflow    <= bus.wr_en && bus.full;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_ok) begin
      mem[wbin[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  // In FWFT mode the pointer-level empty only gates prefetch into the output
  // register; the visible empty tracks whether that register holds a word.
  always_comb begin
    fetch          = 1'b0;
    out_valid_next = out_valid;
    if (MODE == FIFO_FWFT) begin
      fetch = !ptr_empty && (!out_valid || bus.rd_en);
      if (fetch) begin
        out_valid_next = 1'b1;
      end else if (bus.rd_en) begin
        out_valid_next = 1'b0;
      end
    end else begin
      fetch = bus.rd_en && !ptr_empty;
    end
    rbin_next  = rbin + PW'(fetch);
    rgray_next = PW'(bin2gray(PTR_MAX_W'(rbin_next)));
    wsync_bin  = PW'(gray2bin(PTR_MAX_W'(wsync)));
    rfill_next = wsync_bin - rbin_next;
  end

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      rbin             <= '0;
      rgray            <= '0;
      ptr_empty        <= 1'b1;
      out_valid        <= 1'b0;
      bus.rd_data      <= '0;
      bus.almost_empty <= 1'b1;
      bus.rd_count     <= '0;
      bus.underflow    <= 1'b0;
    end else begin
      rbin             <= rbin_next;
      rgray            <= rgray_next;
      ptr_empty        <= (rgray_next == wsync);
      out_valid        <= out_valid_next;
      if (fetch) begin
        bus.rd_data <= mem[rbin[ADDR_WIDTH-1:0]];
      end
      bus.almost_empty <= (rfill_next <= PW'(AEMPTY_THRESH));
      bus.rd_count     <= rfill_next;
      bus.underflow    <= bus.rd_en && bus.empty;
    end
  end

  assign bus.empty = (MODE == FIFO_FWFT) ? !out_valid : ptr_empty;

endmodule

// File: tb/tb_async_fifo_flags.sv
// Bench for async_fifo_flags: a standard-read and an FWFT instance (DEPTH=8)
// checked against per-instance scoreboards under directed and random traffic.
`timescale 1ns/100ps
module tb_async_fifo_flags;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SYNC  = 2;

  logic wr_clk   = 1'b0;
  logic rd_clk   = 1'b0;
  logic wr_reset = 1'b0;
  logic rd_reset = 1'b0;
  real  wr_half  = 5.0;
  real  rd_half  = 13.5;

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  async_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f0 ();
  async_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f1 ();

  async_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC),
    .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0)
  ) dut0 (
    .wr_clk(wr_clk), .wr_reset(wr_reset), .rd_clk(rd_clk), .rd_reset(rd_reset), .bus(f0.slave)
  );

  async_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC),
    .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1)
  ) dut1 (
    .wr_clk(wr_clk), .wr_reset(wr_reset), .rd_clk(rd_clk), .rd_reset(rd_reset), .bus(f1.slave)
  );

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic          wr_done  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    f0.wr_en = 1'b0; f0.rd_en = 1'b0; f0.wr_data = '0;
    f1.wr_en = 1'b0; f1.rd_en = 1'b0; f1.wr_data = '0;
    wr_reset = 1'b1;
    rd_reset = 1'b1;
    #1;
    check_eq("rst_empty",        32'(f0.empty),        32'd1);
    check_eq("rst_almost_empty", 32'(f0.almost_empty), 32'd1);
    check_eq("rst_full",         32'(f0.full),         32'd0);
    check_eq("rst_almost_full",  32'(f0.almost_full),  32'd0);
    check_eq("rst_wr_count",     32'(f0.wr_count),     32'd0);
    check_eq("rst_rd_count",     32'(f0.rd_count),     32'd0);
    check_eq("rst_overflow",     32'(f0.overflow),     32'd0);
    check_eq("rst_underflow",    32'(f0.underflow),    32'd0);
    check_eq("rst_rd_data",      32'(f0.rd_data),      32'd0);
    check_eq("rst_fwft_empty",   32'(f1.empty),        32'd1);
    q0.delete();
    q1.delete();
    repeat (3) @(negedge rd_clk);
    wr_reset = 1'b0;
    #3 rd_reset = 1'b0;
    repeat (2) @(negedge rd_clk);
  endtask

  task automatic write0(input logic [DW-1:0] d);
    @(negedge wr_clk);
    f0.wr_en   = 1'b1;
    f0.wr_data = d;
    if (!f0.full) q0.push_back(d);
    @(negedge wr_clk);
    f0.wr_en = 1'b0;
  endtask

  task automatic wait_rd0(input int unsigned lvl, input string tag);
    for (int n = 0; n < 16 && 32'(f0.rd_count) != lvl; n++) @(negedge rd_clk);
    check_eq(tag, 32'(f0.rd_count), lvl);
  endtask

  task automatic pop0(input string tag);
    @(negedge rd_clk) f0.rd_en = 1'b1;
    @(negedge rd_clk) f0.rd_en = 1'b0;
    if (q0.size() == 0) check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    else                check_eq(tag, 32'(f0.rd_data), 32'(q0.pop_front()));
  endtask

  task automatic run_random(input real wh, input real rh);
    wr_half = wh;
    rd_half = rh;
    do_reset();
    wr_done = 1'b0;
    fork
      begin : writer
        logic          wen, ovf_exp;
        logic [DW-1:0] d;
        ovf_exp = 1'b0;
        for (int unsigned k = 0; k < 2500; k++) begin
          @(negedge wr_clk);
          check_eq("rnd_overflow", 32'(f0.overflow), 32'(ovf_exp));
          check_eq("rnd_wcnt_max0", 32'(32'(f0.wr_count) <= DEPTH), 32'd1);
          check_eq("rnd_wcnt_max1", 32'(32'(f1.wr_count) <= DEPTH), 32'd1);
          check_eq("rnd_full_cnt0", 32'(f0.full), 32'(32'(f0.wr_count) == DEPTH));
          wen = ($urandom_range(0, 99) < 55);
          d   = DW'($urandom);
          f0.wr_en = wen; f0.wr_data = d;
          f1.wr_en = wen; f1.wr_data = d;
          if (wen && !f0.full) q0.push_back(d);
          if (wen && !f1.full) q1.push_back(d);
          ovf_exp = wen && f0.full;
        end
        @(negedge wr_clk);
        f0.wr_en = 1'b0;
        f1.wr_en = 1'b0;
        wr_done  = 1'b1;
      end
      begin : reader
        logic        ren, pend0, unf_exp;
        int unsigned tail;
        pend0 = 1'b0; unf_exp = 1'b0; tail = 0;
        while (tail < 40) begin
          @(negedge rd_clk);
          if (wr_done) tail++;
          if (pend0) begin
            if (q0.size() == 0) check_eq("rnd_sb0_empty", 32'd0, 32'd1);
            else                check_eq("rnd_data0", 32'(f0.rd_data), 32'(q0.pop_front()));
          end
          check_eq("rnd_underflow", 32'(f0.underflow), 32'(unf_exp));
          check_eq("rnd_rcnt_max0", 32'(32'(f0.rd_count) <= DEPTH), 32'd1);
          check_eq("rnd_rcnt_max1", 32'(32'(f1.rd_count) <= DEPTH), 32'd1);
          check_eq("rnd_empty_cnt0", 32'(f0.empty), 32'(f0.rd_count == '0));
          if (!f1.empty) begin
            if (q1.size() == 0) check_eq("rnd_sb1_empty", 32'd0, 32'd1);
            else                check_eq("rnd_head1", 32'(f1.rd_data), 32'(q1[0]));
          end
          ren = wr_done ? 1'b1 : ($urandom_range(0, 99) < 50);
          f0.rd_en = ren;
          f1.rd_en = ren;
          pend0    = ren && !f0.empty;
          unf_exp  = ren && f0.empty;
          if (ren && !f1.empty && q1.size() != 0) void'(q1.pop_front());
        end
        f0.rd_en = 1'b0;
        f1.rd_en = 1'b0;
        if (pend0) begin
          @(negedge rd_clk);
          if (q0.size() != 0) check_eq("rnd_data0_last", 32'(f0.rd_data), 32'(q0.pop_front()));
        end
      end
    join
    check_eq("rnd_drain0", 32'(q0.size()), 32'd0);
    check_eq("rnd_drain1", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    do_reset();

    for (int unsigned i = 0; i < 8; i++) begin
      write0(DW'(i));
      check_eq("fill_wr_count",    32'(f0.wr_count),    i + 1);
      check_eq("fill_almost_full", 32'(f0.almost_full), 32'(i + 1 >= 6));
      check_eq("fill_full",        32'(f0.full),        32'(i == 7));
    end
    write0(8'hFF);
    check_eq("ovf_pulse",    32'(f0.overflow), 32'd1);
    check_eq("ovf_wr_count", 32'(f0.wr_count), 32'd8);
    @(negedge wr_clk);
    check_eq("ovf_clear",    32'(f0.overflow), 32'd0);

    wait_rd0(8, "rd_sync_8");
    check_eq("pre_drain_empty",  32'(f0.empty),        32'd0);
    check_eq("pre_drain_aempty", 32'(f0.almost_empty), 32'd0);
    @(negedge rd_clk) f0.rd_en = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      if (i == 7) f0.rd_en = 1'b0;
      check_eq("drain_data",   32'(f0.rd_data),      32'(q0.pop_front()));
      check_eq("drain_empty",  32'(f0.empty),        32'(i == 7));
      check_eq("drain_count",  32'(f0.rd_count),     7 - i);
      check_eq("drain_aempty", 32'(f0.almost_empty), 32'(7 - i <= 2));
    end
    @(negedge rd_clk) f0.rd_en = 1'b1;
    @(negedge rd_clk) f0.rd_en = 1'b0;
    check_eq("unf_pulse", 32'(f0.underflow), 32'd1);
    check_eq("unf_hold",  32'(f0.rd_data),   32'd7);
    check_eq("unf_empty", 32'(f0.empty),     32'd1);
    @(negedge rd_clk);
    check_eq("unf_clear", 32'(f0.underflow), 32'd0);

    for (int n = 0; n < 16 && f0.wr_count != '0; n++) @(negedge wr_clk);
    check_eq("wr_drain_count", 32'(f0.wr_count), 32'd0);
    check_eq("wr_drain_full",  32'(f0.full),     32'd0);

    for (int unsigned v = 0; v < 40; v++) begin
      write0(DW'(v));
      check_eq("wrap_full",  32'(f0.full),        32'd0);
      check_eq("wrap_afull", 32'(f0.almost_full), 32'd0);
      wait_rd0(1, "wrap_vis");
      pop0("wrap_data");
      check_eq("wrap_empty", 32'(f0.empty),    32'd1);
      check_eq("wrap_count", 32'(f0.rd_count), 32'd0);
    end

    for (int unsigned i = 0; i < 5; i++) write0(DW'(8'h10 + i));
    wait_rd0(5, "stored5");
    do_reset();
    write0(8'h3C);
    wait_rd0(1, "post_rst_vis");
    pop0("post_rst_data");

    @(negedge wr_clk);
    f1.wr_en   = 1'b1;
    f1.wr_data = 8'hA5;
    q1.push_back(8'hA5);
    @(posedge wr_clk);
    #0.1 f1.wr_en = 1'b0;
    for (int n = 0; n < SYNC + 2 && f1.empty; n++) begin
      @(posedge rd_clk);
      #0.1;
    end
    check_eq("fwft_empty", 32'(f1.empty),   32'd0);
    check_eq("fwft_data",  32'(f1.rd_data), 32'(q1[0]));
    @(negedge rd_clk);
    f1.rd_en = 1'b1;
    void'(q1.pop_front());
    @(negedge rd_clk);
    f1.rd_en = 1'b0;
    check_eq("fwft_pop_empty", 32'(f1.empty),     32'd1);
    check_eq("fwft_pop_unf",   32'(f1.underflow), 32'd0);

    run_random(5.0, 13.5);
    run_random(13.5, 5.0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
